// File: rtl/cbus_arbiter_pkg.sv
// Shared cache-bus types, size/length encodings and arbiter state enum.
package cbus_arbiter_pkg;

    // Transfer size per beat
    localparam logic [1:0] MSIZE1 = 2'd0;
    localparam logic [1:0] MSIZE2 = 2'd1;
    localparam logic [1:0] MSIZE4 = 2'd2;

    // Burst length, encoded as beats-1
    localparam logic [3:0] MLEN1 = 4'd0;
    localparam logic [3:0] MLEN2 = 4'd1;
    localparam logic [3:0] MLEN4 = 4'd3;
    localparam logic [3:0] MLEN8 = 4'd7;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [3:0]  len;
        logic [3:0]  strobe;
        logic [31:0] data;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/cbus_arbiter_rr_select.sv
// Round-robin picker: first set bit of vld at or above ptr, wrapping to 0.
module cbus_arbiter_rr_select #(
    parameter int N_REQ = 2,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] vld,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             any_valid
);

    logic [IDX_W:0] cand;

    // Scan from the farthest offset down so the nearest valid entry wins.
    always_comb begin
        idx       = '0;
        any_valid = 1'b0;
        cand      = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = {1'b0, ptr} + (IDX_W + 1)'(i);
            if (cand >= (IDX_W + 1)'(N_REQ))
                cand = cand - (IDX_W + 1)'(N_REQ);
            if (vld[cand[IDX_W-1:0]]) begin
                idx       = cand[IDX_W-1:0];
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cbus_arbiter.sv
// Round-robin arbiter sharing one cache bus among N_REQ requesters.
// The grant is locked for a whole burst and released only on ready&last.
module cbus_arbiter
    import cbus_arbiter_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  cbus_req_t  [N_REQ-1:0] ireqs,
    output cbus_resp_t [N_REQ-1:0] iresps,
    output cbus_req_t              oreq,
    input  cbus_resp_t             oresp,
    output logic                   busy,
    output logic [IDX_W-1:0]       grant_idx
);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [N_REQ-1:0] req_vld;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_any;

    // Gather the valid bits for the selector.
    always_comb begin
        req_vld = '0;
        for (int i = 0; i < N_REQ; i++)
            req_vld[i] = ireqs[i].valid;
    end

    cbus_arbiter_rr_select #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_select (
        .vld       (req_vld),
        .ptr       (rr_ptr_q),
        .idx       (sel_idx),
        .any_valid (sel_any)
    );

    // Control state; reset drops an in-flight burst immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Next-state and bus steering: pass-through only for the owner while BUSY.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        oreq     = '0;
        iresps   = '0;
        case (state_q)
            IDLE: begin
                if (sel_any) begin
                    grant_d = sel_idx;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                oreq            = ireqs[grant_q];
                iresps[grant_q] = oresp;
                if (oresp.ready && oresp.last) begin
                    state_d = IDLE;
                    if (grant_q == IDX_W'(N_REQ - 1))
                        rr_ptr_d = '0;
                    else
                        rr_ptr_d = grant_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy      = (state_q == BUSY);
    assign grant_idx = grant_q;

endmodule

// File: tb/tb_cbus_arbiter.sv
// Directed scenarios plus a random phase, checked against a behavioural model.
module tb_cbus_arbiter;
    import cbus_arbiter_pkg::*;

    localparam int N  = 2;
    localparam int IW = 1;

    logic                 clk = 1'b0;
    logic                 reset;
    cbus_req_t  [N-1:0]   ireqs;
    cbus_resp_t [N-1:0]   iresps;
    cbus_req_t            oreq;
    cbus_resp_t           oresp;
    logic                 busy;
    logic [IW-1:0]        grant_idx;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: owner (if any) and next round-robin start point
    bit m_busy;
    int m_grant;
    int m_ptr;

    always #5 clk = ~clk;

    cbus_arbiter #(.N_REQ(N), .IDX_W(IW)) dut (
        .clk       (clk),
        .reset     (reset),
        .ireqs     (ireqs),
        .iresps    (iresps),
        .oreq      (oreq),
        .oresp     (oresp),
        .busy      (busy),
        .grant_idx (grant_idx)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic cbus_req_t mk_req(input bit wr, input logic [31:0] addr,
                                         input logic [3:0] len, input logic [3:0] strb,
                                         input logic [31:0] data);
        cbus_req_t r;
        r          = '0;
        r.valid    = 1'b1;
        r.is_write = wr;
        r.addr     = addr;
        r.size     = MSIZE4;
        r.len      = len;
        r.strobe   = strb;
        r.data     = data;
        return r;
    endfunction

    function automatic cbus_resp_t mk_resp(input bit rdy, input bit lst, input logic [31:0] d);
        cbus_resp_t r;
        r.ready = rdy;
        r.last  = lst;
        r.data  = d;
        return r;
    endfunction

    // Compare every output with the model, then advance the model across one edge.
    task automatic step();
        cbus_req_t              eq;
        cbus_resp_t [N-1:0]     er;
        bit nb;
        int ng, np;
        bit found;
        @(negedge clk);
        eq = '0;
        er = '0;
        if (m_busy) begin
            eq         = ireqs[m_grant];
            er[m_grant] = oresp;
        end
        chk("busy",   128'(busy),   128'(m_busy));
        chk("oreq",   128'(oreq),   128'(eq));
        chk("iresps", 128'(iresps), 128'(er));
        if (m_busy) chk("grant_idx", 128'(grant_idx), 128'(m_grant));
        nb = m_busy; ng = m_grant; np = m_ptr;
        if (reset) begin
            nb = 1'b0; ng = 0; np = 0;
        end else if (!m_busy) begin
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                if (!found && ireqs[(m_ptr + k) % N].valid) begin
                    found = 1'b1;
                    nb    = 1'b1;
                    ng    = (m_ptr + k) % N;
                end
            end
        end else if (oresp.ready && oresp.last) begin
            nb = 1'b0;
            np = (m_grant + 1) % N;
        end
        @(posedge clk);
        m_busy = nb; m_grant = ng; m_ptr = np;
        #1;
    endtask

    initial begin
        bit [N-1:0] done;
        m_busy = 1'b0; m_grant = 0; m_ptr = 0;
        reset = 1'b1;
        ireqs = '0;
        oresp = '0;
        #1;
        chk("rst_busy",   128'(busy),      128'(0));
        chk("rst_grant",  128'(grant_idx), 128'(0));
        chk("rst_oreq",   128'(oreq),      128'(0));
        chk("rst_iresps", 128'(iresps),    128'(0));
        step();
        step();
        reset = 1'b0;

        // Single 4-beat read from requester 1
        ireqs[1] = mk_req(1'b0, 32'h1000_0040, MLEN4, 4'h0, 32'h0);
        step();
        chk("t1_addr",  128'(oreq.addr), 128'(32'h1000_0040));
        chk("t1_grant", 128'(grant_idx), 128'(1));
        for (int b = 0; b < 4; b++) begin
            oresp = mk_resp(1'b1, b == 3, 32'hA0 + 32'(b));
            #1;
            chk("t1_data",  128'(iresps[1].data), 128'(32'hA0 + b));
            chk("t1_other", 128'(iresps[0]),      128'(0));
            step();
        end
        ireqs[1] = '0;
        oresp    = '0;
        #1;
        chk("t1_release", 128'(busy), 128'(0));

        // Both requesters contending: 0,1,0,1 with a bubble between bursts
        ireqs[0] = mk_req(1'b0, 32'h0000_2000, MLEN4, 4'h0, 32'h0);
        ireqs[1] = mk_req(1'b0, 32'h0000_3000, MLEN4, 4'h0, 32'h0);
        for (int g = 0; g < 4; g++) begin
            chk("rr_bubble", 128'(oreq.valid), 128'(0));
            step();
            chk("rr_grant", 128'(grant_idx), 128'(g % 2));
            chk("rr_busy",  128'(busy),      128'(1));
            for (int b = 0; b < 4; b++) begin
                oresp = mk_resp(1'b1, b == 3, 32'h10 * 32'(g) + 32'(b));
                step();
            end
            oresp = '0;
        end
        ireqs[0] = '0;

        // Late requester 0 arrives while 1 owns the bus
        step();
        chk("late_own", 128'(grant_idx), 128'(1));
        oresp = mk_resp(1'b1, 1'b0, 32'h1);
        step();
        ireqs[0] = mk_req(1'b1, 32'h0000_4000, MLEN4, 4'hF, 32'h1234);
        for (int b = 1; b < 4; b++) begin
            oresp = mk_resp(1'b1, b == 3, 32'(b));
            #1;
            chk("late_oreq", 128'(oreq.addr),       128'(32'h0000_3000));
            chk("late_rdy0", 128'(iresps[0].ready), 128'(0));
            step();
        end
        ireqs[1] = '0;
        oresp    = '0;
        step();
        chk("late_grant", 128'(grant_idx), 128'(0));
        chk("late_busy",  128'(busy),      128'(1));

        // last without ready must not release
        for (int c = 0; c < 3; c++) begin
            oresp = mk_resp(1'b0, 1'b1, 32'h0);
            step();
            chk("split_hold",  128'(busy),      128'(1));
            chk("split_grant", 128'(grant_idx), 128'(0));
        end
        oresp = mk_resp(1'b1, 1'b1, 32'h55);
        step();
        oresp    = '0;
        ireqs[0] = '0;
        #1;
        chk("split_release", 128'(busy), 128'(0));

        // Reset mid-burst (rr_ptr is 1, so requester 1 wins first)
        ireqs[0] = mk_req(1'b0, 32'h0000_5000, MLEN4, 4'h0, 32'h0);
        ireqs[1] = mk_req(1'b1, 32'h0000_6000, MLEN4, 4'hF, 32'hCAFE);
        step();
        chk("mrst_own", 128'(grant_idx), 128'(1));
        for (int b = 0; b < 2; b++) begin
            oresp = mk_resp(1'b1, 1'b0, 32'h0);
            step();
        end
        reset = 1'b1;
        #1;
        chk("mrst_valid", 128'(oreq.valid), 128'(0));
        chk("mrst_busy",  128'(busy),       128'(0));
        chk("mrst_grant", 128'(grant_idx),  128'(0));
        m_busy = 1'b0; m_grant = 0; m_ptr = 0;
        oresp = '0;
        step();
        reset = 1'b0;
        step();
        chk("mrst_regrant", 128'(grant_idx), 128'(0));
        oresp = mk_resp(1'b1, 1'b1, 32'h0);
        step();
        ireqs = '0;
        oresp = '0;
        #1;
        chk("mrst_release", 128'(busy), 128'(0));

        // Uncached single-beat write forwarded bit-exact
        ireqs[1] = mk_req(1'b1, 32'h1F00_0008, MLEN1, 4'b0011, 32'hDEAD_BEEF);
        step();
        chk("uc_oreq",  128'(oreq),      128'(ireqs[1]));
        chk("uc_grant", 128'(grant_idx), 128'(1));
        oresp = mk_resp(1'b1, 1'b1, 32'h0);
        step();
        ireqs[1] = '0;
        oresp    = '0;
        #1;
        chk("uc_release", 128'(busy), 128'(0));

        // Random traffic; requesters hold until they see their own last
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!ireqs[i].valid && ($urandom % 3 == 0))
                    ireqs[i] = mk_req(1'($urandom), $urandom, 4'($urandom), 4'($urandom), $urandom);
            end
            oresp = mk_resp(1'($urandom), ($urandom % 3) == 0, $urandom);
            for (int i = 0; i < N; i++)
                done[i] = m_busy && (m_grant == i) && oresp.ready && oresp.last;
            step();
            for (int i = 0; i < N; i++)
                if (done[i]) ireqs[i] = '0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
